// File: rtl/control_divisor_pkg.sv
// Shared constants for the divider sequencing controller: FSM state
// encodings and LED mux select codes.
package control_divisor_pkg;

    typedef enum logic [2:0] {
        S_NUM = 3'd0,
        S_DEN = 3'd1,
        S_RUN = 3'd2,
        S_RES = 3'd3,
        S_REM = 3'd4,
        S_ERR = 3'd5
    } state_t;

    localparam logic [1:0] SEL_NUM = 2'b00;
    localparam logic [1:0] SEL_DEN = 2'b01;
    localparam logic [1:0] SEL_RES = 2'b10;
    localparam logic [1:0] SEL_REM = 2'b11;

endpackage

// File: rtl/control_divisor_antirrebote.sv
// Button conditioner: 2-FF synchronizer, debounce counter and a one-cycle
// pulse on the released->pressed transition of an active-low button.
module antirrebote #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          press_r;
    logic [CW-1:0] cnt_r;

    // Synchronize, count disagreement cycles and flip the accepted level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            level_r <= 1'b1;
            press_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            press_r <= 1'b0;
            if (sync2_r == level_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                // Accepting a low level is a press; accepting a high is silent.
                level_r <= sync2_r;
                cnt_r   <= '0;
                press_r <= ~sync2_r;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/control_divisor.sv
// Sequencing controller for the 4-bit divider: button conditioning,
// counter steering, divider start/done handshake with timeout, error trap.
module control_divisor
    import control_divisor_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int TIMEOUT    = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       down,
    input  logic       ok,
    input  logic [3:0] den,
    input  logic       div_done,
    output logic       en_num,
    output logic       en_den,
    output logic       inc,
    output logic       dec,
    output logic       div_start,
    output logic [1:0] sel,
    output logic       err,
    output logic       busy
);

    localparam logic [4:0] TMO_LAST = 5'(TIMEOUT - 1);

    logic up_p;
    logic down_p;
    logic ok_p;
    logic up_act;
    logic down_act;

    state_t     state_r;
    state_t     state_nx;
    logic [4:0] tmo_r;
    logic [4:0] tmo_nx;

    logic [1:0] sel_r,    sel_nx;
    logic       en_num_r, en_num_nx;
    logic       en_den_r, en_den_nx;
    logic       busy_r,   busy_nx;
    logic       err_r,    err_nx;

    antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up   (.clk(clk), .rst(rst), .raw(up),   .press(up_p));
    antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (.clk(clk), .rst(rst), .raw(down), .press(down_p));
    antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ok   (.clk(clk), .rst(rst), .raw(ok),   .press(ok_p));

    // ok wins over up/down; simultaneous up and down cancel out.
    assign up_act   = up_p & ~down_p & ~ok_p;
    assign down_act = down_p & ~up_p & ~ok_p;

    // Next-state logic plus the decoded inc/dec/div_start strobes.
    always_comb begin
        state_nx  = state_r;
        tmo_nx    = 5'd0;
        inc       = 1'b0;
        dec       = 1'b0;
        div_start = 1'b0;
        case (state_r)
            S_NUM: begin
                inc = up_act;
                dec = down_act;
                if (ok_p) state_nx = S_DEN;
                else      state_nx = S_NUM;
            end
            S_DEN: begin
                inc = up_act;
                dec = down_act;
                if (ok_p) begin
                    if (den == 4'd0) begin
                        state_nx = S_ERR;
                    end else begin
                        state_nx  = S_RUN;
                        div_start = 1'b1;
                    end
                end else begin
                    state_nx = S_DEN;
                end
            end
            S_RUN: begin
                if (div_done) begin
                    state_nx = S_RES;
                end else if (tmo_r == TMO_LAST) begin
                    state_nx = S_ERR;
                end else begin
                    state_nx = S_RUN;
                    tmo_nx   = tmo_r + 5'd1;
                end
            end
            S_RES: begin
                if (ok_p) state_nx = S_REM;
                else      state_nx = S_RES;
            end
            S_REM: begin
                if (ok_p) state_nx = S_NUM;
                else      state_nx = S_REM;
            end
            S_ERR: begin
                if (ok_p) state_nx = S_NUM;
                else      state_nx = S_ERR;
            end
            default: begin
                state_nx = S_NUM;
            end
        endcase
    end

    // Output levels for the upcoming state, registered alongside it.
    always_comb begin
        sel_nx    = SEL_NUM;
        en_num_nx = 1'b0;
        en_den_nx = 1'b0;
        busy_nx   = 1'b0;
        err_nx    = 1'b0;
        case (state_nx)
            S_NUM:   begin sel_nx = SEL_NUM; en_num_nx = 1'b1; end
            S_DEN:   begin sel_nx = SEL_DEN; en_den_nx = 1'b1; end
            S_RUN:   begin sel_nx = SEL_RES; busy_nx   = 1'b1; end
            S_RES:   begin sel_nx = SEL_RES; end
            S_REM:   begin sel_nx = SEL_REM; end
            S_ERR:   begin sel_nx = SEL_RES; err_nx    = 1'b1; end
            default: begin sel_nx = SEL_NUM; en_num_nx = 1'b1; end
        endcase
    end

    // State, timeout counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= S_NUM;
            tmo_r    <= 5'd0;
            sel_r    <= SEL_NUM;
            en_num_r <= 1'b1;
            en_den_r <= 1'b0;
            busy_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_nx;
            tmo_r    <= tmo_nx;
            sel_r    <= sel_nx;
            en_num_r <= en_num_nx;
            en_den_r <= en_den_nx;
            busy_r   <= busy_nx;
            err_r    <= err_nx;
        end
    end

    assign sel    = sel_r;
    assign en_num = en_num_r;
    assign en_den = en_den_r;
    assign busy   = busy_r;
    assign err    = err_r;

endmodule

// File: tb/tb_control_divisor.sv
// Directed bench for control_divisor with DEB_CYCLES=4, TIMEOUT=31.
module tb_control_divisor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up = 1'b1;
    logic       down = 1'b1;
    logic       ok = 1'b1;
    logic [3:0] den = 4'd3;
    logic       div_done = 1'b0;
    logic       en_num, en_den, inc, dec, div_start, err, busy;
    logic [1:0] sel;

    int n_vec = 0;
    int n_err = 0;
    int n_inc = 0;
    int n_dec = 0;
    int n_start = 0;

    control_divisor #(.DEB_CYCLES(4), .TIMEOUT(31)) dut (
        .clk(clk), .rst(rst), .up(up), .down(down), .ok(ok), .den(den),
        .div_done(div_done), .en_num(en_num), .en_den(en_den), .inc(inc),
        .dec(dec), .div_start(div_start), .sel(sel), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        n_inc   += int'(inc);
        n_dec   += int'(dec);
        n_start += int'(div_start);
    endtask

    task automatic clear_counts();
        n_inc = 0; n_dec = 0; n_start = 0;
    endtask

    task automatic press_ok();
        ok = 1'b0;
        repeat (10) tick();
        ok = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #2;
        n_vec++;
        if ({sel, en_num, en_den, inc, dec, div_start, err, busy} !== 9'b00_1000000) begin
            n_err++;
            $display("FAIL reset_async: got %b want 001000000", {sel, en_num, en_den, inc, dec, div_start, err, busy});
        end
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();
        n_vec++;
        if ({sel, en_num, en_den, err, busy} !== 6'b00_1000) begin
            n_err++;
            $display("FAIL reset_release: got %b want 001000", {sel, en_num, en_den, err, busy});
        end
    endtask

    task automatic test_up();
        int first;
        logic bad;
        clear_counts();
        for (int p = 0; p < 3; p++) begin
            first = 0;
            bad = 1'b0;
            up = 1'b0;
            for (int i = 1; i <= 10; i++) begin
                tick();
                if (inc) begin
                    if (first == 0) first = i;
                    if (!(en_num === 1'b1 && en_den === 1'b0 && sel === 2'b00)) bad = 1'b1;
                end
            end
            up = 1'b1;
            repeat (10) tick();
            n_vec++;
            if (first != 6 || bad) begin
                n_err++;
                $display("FAIL up_latency: press %0d pulse at %0d bad_ctx %b want 6 0", p, first, bad);
            end
        end
        n_vec++;
        if (n_inc != 3 || n_dec != 0) begin
            n_err++;
            $display("FAIL up_count: inc %0d dec %0d want 3 0", n_inc, n_dec);
        end
    endtask

    task automatic test_glitch();
        clear_counts();
        down = 1'b0;
        tick(); tick();
        down = 1'b1;
        repeat (12) tick();
        n_vec++;
        if (n_dec != 0) begin
            n_err++;
            $display("FAIL glitch: dec %0d want 0", n_dec);
        end
        up = 1'b0; down = 1'b0;
        repeat (10) tick();
        up = 1'b1; down = 1'b1;
        repeat (10) tick();
        n_vec++;
        if (n_inc != 0 || n_dec != 0 || sel !== 2'b00) begin
            n_err++;
            $display("FAIL up_down_both: inc %0d dec %0d sel %b want 0 0 00", n_inc, n_dec, sel);
        end
    endtask

    task automatic test_div_zero();
        den = 4'd0;
        press_ok();
        n_vec++;
        if (sel !== 2'b01 || en_den !== 1'b1 || en_num !== 1'b0) begin
            n_err++;
            $display("FAIL to_den: sel %b en_den %b en_num %b want 01 1 0", sel, en_den, en_num);
        end
        clear_counts();
        press_ok();
        n_vec++;
        if (err !== 1'b1 || sel !== 2'b10 || busy !== 1'b0 || n_start != 0) begin
            n_err++;
            $display("FAIL div_zero: err %b sel %b busy %b starts %0d want 1 10 0 0", err, sel, busy, n_start);
        end
        press_ok();
        n_vec++;
        if (err !== 1'b0 || sel !== 2'b00 || en_num !== 1'b1) begin
            n_err++;
            $display("FAIL err_exit: err %b sel %b en_num %b want 0 00 1", err, sel, en_num);
        end
    endtask

    task automatic test_divide();
        den = 4'd3;
        press_ok();
        clear_counts();
        ok = 1'b0;
        repeat (5) tick();
        n_vec++;
        if (n_start != 0) begin
            n_err++;
            $display("FAIL start_early: starts %0d want 0", n_start);
        end
        tick();
        n_vec++;
        if (div_start !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_pulse: div_start %b busy %b want 1 0", div_start, busy);
        end
        tick();
        n_vec++;
        if (busy !== 1'b1 || sel !== 2'b10 || div_start !== 1'b0) begin
            n_err++;
            $display("FAIL run_state: busy %b sel %b div_start %b want 1 10 0", busy, sel, div_start);
        end
        repeat (3) tick();
        div_done = 1'b1;
        tick();
        div_done = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || sel !== 2'b10 || err !== 1'b0) begin
            n_err++;
            $display("FAIL done_to_res: busy %b sel %b err %b want 0 10 0", busy, sel, err);
        end
        repeat (3) tick();
        ok = 1'b1;
        repeat (10) tick();
        n_vec++;
        if (n_start != 1 || sel !== 2'b10) begin
            n_err++;
            $display("FAIL single_start: starts %0d sel %b want 1 10", n_start, sel);
        end
        press_ok();
        n_vec++;
        if (sel !== 2'b11) begin
            n_err++;
            $display("FAIL to_rem: sel %b want 11", sel);
        end
        press_ok();
        n_vec++;
        if (sel !== 2'b00 || en_num !== 1'b1) begin
            n_err++;
            $display("FAIL rem_to_num: sel %b en_num %b want 00 1", sel, en_num);
        end
    endtask

    task automatic test_timeout();
        den = 4'd3;
        press_ok();
        clear_counts();
        for (int i = 1; i <= 45; i++) begin
            ok = (i <= 7) ? 1'b0 : (i <= 15) ? 1'b1 : (i <= 25) ? 1'b0 : 1'b1;
            tick();
            if (i == 6) begin
                n_vec++;
                if (div_start !== 1'b1) begin
                    n_err++;
                    $display("FAIL tmo_start: div_start %b want 1", div_start);
                end
            end
            if (i == 37) begin
                n_vec++;
                if (busy !== 1'b1 || err !== 1'b0 || sel !== 2'b10) begin
                    n_err++;
                    $display("FAIL tmo_last_run: busy %b err %b sel %b want 1 0 10", busy, err, sel);
                end
            end
            if (i == 38) begin
                n_vec++;
                if (err !== 1'b1 || busy !== 1'b0 || sel !== 2'b10) begin
                    n_err++;
                    $display("FAIL tmo_err: err %b busy %b sel %b want 1 0 10", err, busy, sel);
                end
            end
        end
        repeat (10) tick();
        n_vec++;
        if (err !== 1'b1 || n_start != 1) begin
            n_err++;
            $display("FAIL tmo_hold: err %b starts %0d want 1 1", err, n_start);
        end
        press_ok();
        n_vec++;
        if (err !== 1'b0 || sel !== 2'b00) begin
            n_err++;
            $display("FAIL tmo_exit: err %b sel %b want 0 00", err, sel);
        end
    endtask

    task automatic test_reset_in_run();
        den = 4'd3;
        press_ok();
        ok = 1'b0;
        repeat (8) tick();
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL pre_rst_run: busy %b want 1", busy);
        end
        ok = 1'b1;
        #1 rst = 1'b0;
        #1;
        n_vec++;
        if ({sel, en_num, en_den, inc, dec, div_start, err, busy} !== 9'b00_1000000) begin
            n_err++;
            $display("FAIL rst_in_run: got %b want 001000000", {sel, en_num, en_den, inc, dec, div_start, err, busy});
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (10) tick();
        press_ok();
        n_vec++;
        if (sel !== 2'b01 || en_den !== 1'b1) begin
            n_err++;
            $display("FAIL post_rst_ok: sel %b en_den %b want 01 1", sel, en_den);
        end
    endtask

    initial begin
        test_reset();
        test_up();
        test_glitch();
        test_div_zero();
        test_divide();
        test_timeout();
        test_reset_in_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/control_divisor.md
Name: control_divisor

Overview:
- Sequencing controller for the 4-bit divider top level.
- Replaces the bare 2-bit ok-counter with a real FSM:
  - debounces and edge-detects the three active-low buttons;
  - steers up/down into the numerator or denominator counter;
  - launches the sequential divider with a start/done handshake and watches it with a timeout;
  - traps divide-by-zero;
  - drives the LED mux select.
- Sits between the board buttons and the counters/divider/mux.

Parameters:
- DEB_CYCLES, 4, consecutive stable cycles required before a button level change is accepted (min 1).
- TIMEOUT, 31, maximum cycles to wait for div_done after div_start before declaring an error (min 1, fits 5 bits).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- up  in  1  raw increment button, active-low, asynchronous to clk.
- down  in  1  raw decrement button, active-low.
- ok  in  1  raw advance button, active-low.
- den  in  4  current denominator value, for the zero check.
- div_done  in  1  divider finished; level or pulse, sampled only in S_RUN.
- en_num  out  1  numerator counter enable.
- en_den  out  1  denominator counter enable.
- inc  out  1  one-cycle increment pulse.
- dec  out  1  one-cycle decrement pulse.
- div_start  out  1  one-cycle divider start pulse; divider clears and begins.
- sel  out  2  LED mux select: 00 num, 01 den, 10 result, 11 remainder.
- err  out  1  error indicator: divide-by-zero or timeout.
- busy  out  1  high while in S_RUN.

Behaviour:
- Reset (rst=0, async):
  - state S_NUM; sel=00; en_num=1; all other outputs 0.
  - Debouncers at "released"; sync flops at 1; timeout counter 0.
- Button path, per button:
  - 2-FF synchronizer feeding a debouncer.
  - Counter counts cycles where the synchronized level differs from the accepted level; clears when they are equal.
  - When the count reaches DEB_CYCLES, the accepted level flips and the counter clears.
  - Press pulse is 1 cycle, on the released->pressed flip only. No pulse on release.
  - Latency from a stable low on the raw pin to the pulse is DEB_CYCLES+2 cycles. Glitches shorter than DEB_CYCLES produce no pulse.
- Pulse priority in one cycle:
  - ok beats up/down.
  - up and down together are both ignored.
- States, outputs and transitions:
  - S_NUM: sel=00, en_num=1.
    - up -> inc, down -> dec.
    - ok -> S_DEN.
  - S_DEN: sel=01, en_den=1.
    - up -> inc, down -> dec.
    - ok with den==0 -> S_ERR.
    - ok with den!=0 -> S_RUN; div_start=1 in the transition cycle.
  - S_RUN: sel=10, busy=1.
    - Timeout counter increments each cycle.
    - div_done=1 -> S_RES; counter clears.
    - Counter reaches TIMEOUT without done -> S_ERR.
    - ok, up and down are ignored.
  - S_RES: sel=10.
    - ok -> S_REM.
  - S_REM: sel=11.
    - ok -> S_NUM.
  - S_ERR: sel=10, err=1.
    - ok -> S_NUM; err clears on exit.
- inc and dec are only ever asserted with exactly one of en_num/en_den high. They are 0 in all other states.
- Counters wrap at 4 bits; wrap-around is the counters' concern, not this block's.
- div_start is never asserted outside the S_DEN->S_RUN transition. It is never asserted twice for one entry.
- div_done arriving in the same cycle as div_start is ignored. It is sampled from the first S_RUN cycle.
- All outputs are registered except inc, dec and div_start, which are decoded from state and pulse.
- Reset mid-S_RUN returns to S_NUM immediately. The divider is cleared by the top level from sel[1].
- Unused state encodings recover to S_NUM on the next clock.

Decomposition:
- Shared package, constants only:
  - state encodings S_NUM..S_ERR (3 bits);
  - SEL_NUM=00, SEL_DEN=01, SEL_RES=10, SEL_REM=11.
- One natural sub-module, antirrebote:
  - synchronizer, debounce counter and press-pulse, parameterized by DEB_CYCLES;
  - instantiated three times (up, down, ok).

Test Plan:
- Reset then press up 3 times (each held 10 cycles, DEB_CYCLES=4) -> exactly 3 inc pulses with en_num=1, sel=00. Each pulse arrives 6 cycles after the press.
- 2-cycle low glitch on down -> no dec. Up and down pressed in the same cycle -> neither inc nor dec.
- ok in S_NUM, then ok with den=0 -> sel 01, then err=1, sel=10, no div_start. Another ok -> S_NUM, err=0.
- den=3, ok from S_DEN -> a single 1-cycle div_start, busy=1. div_done after 5 cycles -> S_RES, sel=10. Then ok -> sel=11, ok -> sel=00.
- div_done withheld (TIMEOUT=31) -> err=1 after 31 cycles in S_RUN. ok pressed during S_RUN has no effect.
- rst asserted in S_RUN -> outputs return to reset values asynchronously, before the next clk edge. After rst release, the first ok -> S_DEN.
